// File: rtl/score_keeper.sv
// Scores each light flick against keypad presses: hit/miss counts, reaction time
// and game-over/win status for one game started by a start pulse.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  IDLE       | no game since reset
//  ARM        | game started, waiting for the lights to go dark
//  WAIT_LIGHT | dark, waiting for the next flick
//  LIT        | flick on, reaction timer running, waiting for a key
//  JUDGED     | flick already scored, waiting for the lights to go dark
//  DONE       | game finished, results held until start or reset
module score_keeper #(
  parameter int PASS_MISSES = 5,
  parameter int RT_W        = 28
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            deathmatch_i,
  input  logic [5:0]      total_points_i,
  input  logic [8:0]      lights_i,
  input  logic            key_valid_i,
  input  logic [3:0]      key_code_i,
  output logic [5:0]      hits_o,
  output logic [5:0]      misses_o,
  output logic [5:0]      flicks_o,
  output logic [RT_W-1:0] last_rt_o,
  output logic            hit_pulse_o,
  output logic            miss_pulse_o,
  output logic            busy_o,
  output logic            game_over_o,
  output logic            win_o,
  output logic            lights_err_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARM        = 3'd1,
    WAIT_LIGHT = 3'd2,
    LIT        = 3'd3,
    JUDGED     = 3'd4,
    DONE       = 3'd5
  } state_t;

  localparam logic [5:0] PASS_M = 6'(PASS_MISSES);

  state_t          state_q, state_d;
  logic [5:0]      hits_q, hits_d;
  logic [5:0]      misses_q, misses_d;
  logic [5:0]      flicks_q, flicks_d;
  logic [5:0]      total_q, total_d;
  logic [RT_W-1:0] last_rt_q, last_rt_d;
  logic [RT_W-1:0] rt_q, rt_d;
  logic [RT_W-1:0] rt_inc;
  logic [3:0]      target_q, target_d;
  logic            dm_q, dm_d;
  logic            win_q, win_d;
  logic            err_q, err_d;
  logic            hit_pulse_q, hit_pulse_d;
  logic            miss_pulse_q, miss_pulse_d;
  logic            busy_q, busy_d;
  logic            game_over_q, game_over_d;
  logic            resolve;
  logic [5:0]      miss_res;
  logic            lights_multi;
  logic [3:0]      lights_low;

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'h3f) ? v : v + 6'd1;
  endfunction

  always_comb begin
    lights_low = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (lights_i[i]) lights_low = 4'(i);
    end
  end

  assign lights_multi = (lights_i & (lights_i - 9'd1)) != 9'd0;
  assign rt_inc       = (rt_q == '1) ? rt_q : rt_q + RT_W'(1);

  always_comb begin
    state_d      = state_q;
    hits_d       = hits_q;
    misses_d     = misses_q;
    flicks_d     = flicks_q;
    total_d      = total_q;
    last_rt_d    = last_rt_q;
    rt_d         = rt_q;
    target_d     = target_q;
    dm_d         = dm_q;
    win_d        = win_q;
    err_d        = err_q | lights_multi;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
    resolve      = 1'b0;
    miss_res     = misses_q;

    if (start_i) begin
      hits_d    = '0;
      misses_d  = '0;
      flicks_d  = '0;
      last_rt_d = '0;
      rt_d      = '0;
      err_d     = 1'b0;
      win_d     = 1'b0;
      total_d   = total_points_i;
      dm_d      = deathmatch_i;
      state_d   = ARM;
    end else begin
      unique case (state_q)
        IDLE: ;
        ARM: begin
          if (lights_i == 9'd0) begin
            if (total_q == 6'd0) begin
              state_d = DONE;
              win_d   = 1'b1;
            end else begin
              state_d = WAIT_LIGHT;
            end
          end
        end
        WAIT_LIGHT: begin
          if (lights_i != 9'd0) begin
            target_d = lights_low;
            flicks_d = sat_inc(flicks_q);
            rt_d     = '0;
            state_d  = LIT;
          end
        end
        LIT: begin
          rt_d = rt_inc;
          // A key in the same cycle the light drops is still judged as a press.
          if (key_valid_i) begin
            if (key_code_i == target_q) begin
              hits_d      = sat_inc(hits_q);
              last_rt_d   = rt_inc;
              hit_pulse_d = 1'b1;
            end else begin
              misses_d     = sat_inc(misses_q);
              miss_pulse_d = 1'b1;
            end
            state_d = JUDGED;
          end else if (lights_i == 9'd0) begin
            misses_d     = sat_inc(misses_q);
            miss_pulse_d = 1'b1;
            miss_res     = sat_inc(misses_q);
            resolve      = 1'b1;
          end
        end
        JUDGED: begin
          if (lights_i == 9'd0) resolve = 1'b1;
        end
        DONE: ;
        default: state_d = IDLE;
      endcase

      if (resolve) begin
        if ((dm_q && miss_res != 6'd0) || flicks_q == total_q) begin
          state_d = DONE;
          win_d   = dm_q ? (miss_res == 6'd0) : (miss_res <= PASS_M);
        end else begin
          state_d = WAIT_LIGHT;
        end
      end
    end

    busy_d      = (state_d == ARM) || (state_d == WAIT_LIGHT) ||
                  (state_d == LIT) || (state_d == JUDGED);
    game_over_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      hits_q       <= '0;
      misses_q     <= '0;
      flicks_q     <= '0;
      total_q      <= '0;
      last_rt_q    <= '0;
      rt_q         <= '0;
      target_q     <= '0;
      dm_q         <= 1'b0;
      win_q        <= 1'b0;
      err_q        <= 1'b0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hits_q       <= hits_d;
      misses_q     <= misses_d;
      flicks_q     <= flicks_d;
      total_q      <= total_d;
      last_rt_q    <= last_rt_d;
      rt_q         <= rt_d;
      target_q     <= target_d;
      dm_q         <= dm_d;
      win_q        <= win_d;
      err_q        <= err_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      busy_q       <= busy_d;
      game_over_q  <= game_over_d;
    end
  end

  assign hits_o       = hits_q;
  assign misses_o     = misses_q;
  assign flicks_o     = flicks_q;
  assign last_rt_o    = last_rt_q;
  assign hit_pulse_o  = hit_pulse_q;
  assign miss_pulse_o = miss_pulse_q;
  assign busy_o       = busy_q;
  assign game_over_o  = game_over_q;
  assign win_o        = win_q;
  assign lights_err_o = err_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: stimulus pushes expected pulse/end-of-game
// records computed from the game rules; a negedge monitor pops and compares.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        reset_i, start_i, deathmatch_i, key_valid_i;
  logic [5:0]  total_points_i;
  logic [8:0]  lights_i;
  logic [3:0]  key_code_i;
  logic [5:0]  hits_o, misses_o, flicks_o;
  logic [27:0] last_rt_o;
  logic        hit_pulse_o, miss_pulse_o, busy_o, game_over_o, win_o, lights_err_o;

  always #5 clk = ~clk;

  score_keeper #(.PASS_MISSES(5), .RT_W(28)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .deathmatch_i(deathmatch_i),
    .total_points_i(total_points_i), .lights_i(lights_i), .key_valid_i(key_valid_i),
    .key_code_i(key_code_i), .hits_o(hits_o), .misses_o(misses_o), .flicks_o(flicks_o),
    .last_rt_o(last_rt_o), .hit_pulse_o(hit_pulse_o), .miss_pulse_o(miss_pulse_o),
    .busy_o(busy_o), .game_over_o(game_over_o), .win_o(win_o), .lights_err_o(lights_err_o)
  );

  typedef struct {
    int kind;   // 0 hit, 1 miss, 2 game over
    int hits;
    int misses;
    int flicks;
    int rt;
    int win;
    int err;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // reference game state
  int m_hits, m_misses, m_flicks, m_rt, m_total;
  bit m_dm, m_err, m_over;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind);
    exp_t e;
    e.kind   = kind;
    e.hits   = m_hits;
    e.misses = m_misses;
    e.flicks = m_flicks;
    e.rt     = m_rt;
    e.win    = m_dm ? int'(m_misses == 0) : int'(m_misses <= 5);
    e.err    = int'(m_err);
    q.push_back(e);
  endtask

  // monitor
  logic go_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset_i !== 1'b1) begin
      if (hit_pulse_o || miss_pulse_o) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected_pulse: got hit=%0b miss=%0b expected none", hit_pulse_o, miss_pulse_o);
        end else begin
          e = q.pop_front();
          check("pulse_kind", hit_pulse_o ? 0 : 1, e.kind);
          check("pulse_hits", int'(hits_o), e.hits);
          check("pulse_misses", int'(misses_o), e.misses);
          check("pulse_flicks", int'(flicks_o), e.flicks);
          check("pulse_last_rt", int'(last_rt_o), e.rt);
        end
      end
      if (game_over_o && !go_prev) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected_done: got game_over=1 expected 0");
        end else begin
          e = q.pop_front();
          check("done_kind", 2, e.kind);
          check("done_win", int'(win_o), e.win);
          check("done_hits", int'(hits_o), e.hits);
          check("done_misses", int'(misses_o), e.misses);
          check("done_flicks", int'(flicks_o), e.flicks);
          check("done_lights_err", int'(lights_err_o), e.err);
          check("done_busy", int'(busy_o), 0);
        end
      end
    end
    go_prev = game_over_o;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic [8:0] l, input logic kv, input logic [3:0] kc);
    lights_i    = l;
    key_valid_i = kv;
    key_code_i  = kc;
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [8:0] l);
    for (int i = 0; i < 9; i++) if (l[i]) return i;
    return 0;
  endfunction

  task automatic model_start(input bit dm, input int total);
    m_hits = 0; m_misses = 0; m_flicks = 0; m_rt = 0;
    m_err = 0; m_over = 0; m_dm = dm; m_total = total;
  endtask

  task automatic start_game(input bit dm, input int total);
    start_i = 1'b1; deathmatch_i = dm; total_points_i = 6'(total);
    model_start(dm, total);
    if (total == 0) begin
      m_over = 1;
      push(2);
    end
    step(9'd0, 1'b0, 4'd0);
    start_i = 1'b0;
    step(9'd0, 1'b0, 4'd0);
    step(9'd0, 1'b0, 4'd0);
  endtask

  // One flick: lights l on for n_on cycles; key kc at offset key_off (0 = none,
  // n_on = the cycle the light drops). stray0 presses at the light-on cycle,
  // extra presses once more after a judged key while still lit.
  task automatic flick(input logic [8:0] l, input int n_on, input int key_off,
                       input logic [3:0] kc, input bit stray0, input bit extra, input int gap);
    int         tgt;
    logic [8:0] lv;
    logic       kv;
    logic [3:0] kk;
    tgt = lowest(l);
    m_flicks++;
    if ($countones(l) > 1) m_err = 1;
    if (key_off >= 1 && key_off <= n_on) begin
      if (int'(kc) == tgt) begin
        m_hits++; m_rt = key_off; push(0);
      end else begin
        m_misses++; push(1);
      end
    end else begin
      m_misses++; push(1);
    end
    if ((m_dm && m_misses > 0) || m_flicks == m_total) begin
      m_over = 1;
      push(2);
    end
    for (int c = 0; c <= n_on; c++) begin
      lv = (c < n_on) ? l : 9'd0;
      kv = 1'b0;
      kk = 4'd0;
      if (key_off >= 1 && c == key_off) begin
        kv = 1'b1; kk = kc;
      end else if (c == 0 && stray0) begin
        kv = 1'b1; kk = 4'(tgt);
      end else if (extra && key_off >= 1 && c == key_off + 1 && c < n_on) begin
        kv = 1'b1; kk = 4'($urandom_range(0, 15));
      end
      step(lv, kv, kk);
    end
    for (int c = 0; c < gap; c++) begin
      if ($urandom_range(0, 2) == 0) step(9'd0, 1'b1, 4'($urandom_range(0, 15)));
      else step(9'd0, 1'b0, 4'd0);
    end
  endtask

  task automatic rand_flick();
    logic [8:0] l;
    int         n_on, mode, tgt, key_off;
    logic [3:0] kc;
    l = 9'd1 << $urandom_range(0, 8);
    if ($urandom_range(0, 4) == 0) l = l | (9'd1 << $urandom_range(0, 8));
    tgt  = lowest(l);
    n_on = int'($urandom_range(1, 8));
    mode = int'($urandom_range(0, 3));
    key_off = (mode == 0) ? 0 : int'($urandom_range(1, n_on));
    kc = (mode == 1) ? 4'((tgt + 1 + int'($urandom_range(0, 14))) % 16) : 4'(tgt);
    flick(l, n_on, key_off, kc, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
          int'($urandom_range(2, 4)));
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; deathmatch_i = 1'b0; total_points_i = 6'd0;
    lights_i = 9'd0; key_valid_i = 1'b0; key_code_i = 4'd0;
    @(posedge clk); #1;
    step(9'd0, 1'b0, 4'd0);
    step(9'd0, 1'b0, 4'd0);
    reset_i = 1'b0;
    check("rst_hits", int'(hits_o), 0);
    check("rst_misses", int'(misses_o), 0);
    check("rst_flicks", int'(flicks_o), 0);
    check("rst_last_rt", int'(last_rt_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_game_over", int'(game_over_o), 0);
    check("rst_win", int'(win_o), 0);
    check("rst_lights_err", int'(lights_err_o), 0);

    // hit at reaction time 5, then a timed-out flick ends a normal game
    start_game(1'b0, 2);
    flick(9'b000010000, 10, 5, 4'd4, 1'b0, 1'b1, 3);
    flick(9'b000000010, 4, 0, 4'd0, 1'b0, 1'b0, 3);

    // deathmatch: a wrong key ends the game once the light drops
    start_game(1'b1, 5);
    flick(9'b000000001, 4, 2, 4'd3, 1'b0, 1'b0, 3);

    // key in the same cycle the light falls counts as a hit
    start_game(1'b0, 2);
    flick(9'b001000000, 3, 3, 4'd6, 1'b0, 1'b0, 3);
    flick(9'b100000000, 1, 1, 4'd8, 1'b0, 1'b0, 3);

    // two lights at once: error flag, lowest index is the target
    start_game(1'b0, 1);
    flick(9'b000100100, 5, 3, 4'd2, 1'b1, 1'b0, 3);

    // empty game wins immediately
    start_game(1'b0, 0);
    step(9'd0, 1'b0, 4'd0);

    // reset in the middle of a lit flick
    start_game(1'b0, 3);
    flick(9'b000001000, 4, 2, 4'd3, 1'b0, 1'b0, 2);
    step(9'b010000000, 1'b0, 4'd0);
    step(9'b010000000, 1'b0, 4'd0);
    step(9'b010000000, 1'b0, 4'd0);
    reset_i = 1'b1;
    step(9'd0, 1'b0, 4'd0);
    reset_i = 1'b0;
    check("mid_rst_hits", int'(hits_o), 0);
    check("mid_rst_misses", int'(misses_o), 0);
    check("mid_rst_flicks", int'(flicks_o), 0);
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_game_over", int'(game_over_o), 0);

    // start while a light is still on: hold in ARM until dark
    lights_i = 9'b000001000;
    start_i = 1'b1; deathmatch_i = 1'b0; total_points_i = 6'd1;
    model_start(1'b0, 1);
    step(9'b000001000, 1'b0, 4'd0);
    start_i = 1'b0;
    step(9'b000001000, 1'b0, 4'd0);
    step(9'b000001000, 1'b0, 4'd0);
    step(9'b000001000, 1'b1, 4'd3);
    check("arm_busy", int'(busy_o), 1);
    check("arm_flicks", int'(flicks_o), 0);
    check("arm_misses", int'(misses_o), 0);
    step(9'd0, 1'b0, 4'd0);
    step(9'd0, 1'b0, 4'd0);
    flick(9'b000001000, 3, 0, 4'd0, 1'b0, 1'b0, 3);

    for (int g = 0; g < 30; g++) begin
      int total;
      total = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      start_game(bit'($urandom_range(0, 3) == 0), total);
      while (!m_over) rand_flick();
      step(9'd0, 1'b0, 4'd0);
    end

    for (int i = 0; i < 5; i++) step(9'd0, 1'b0, 4'd0);
    check("sb_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
